// File: rtl/bsg_link_packer_pkg.sv
// Shared types and width helpers for the link upstream packer.
// Slot layout is {last, data}; the struct below describes it at the default beat width.
package bsg_link_packer_pkg;

  localparam int link_in_width_lp = 8;

  typedef struct packed {
    logic                        last;
    logic [link_in_width_lp-1:0] data;
  } link_slot_s;

  typedef enum logic {
    out_empty = 1'b0,
    out_full  = 1'b1
  } out_state_e;

  function automatic int slot_width(input int in_width);
    return in_width + 1;
  endfunction

  function automatic int els_count(input int width, input int in_width);
    return width / slot_width(in_width);
  endfunction

endpackage

// File: rtl/bsg_link_packer_stats.sv
// Packet and word statistics counters for the link packer; wrap modulo 2^count_width_p.
module bsg_link_packer_stats #(
  parameter int count_width_p = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     packet_inc,
  input  logic                     word_inc,
  output logic [count_width_p-1:0] packet_count,
  output logic [count_width_p-1:0] word_count
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      packet_count <= '0;
      word_count   <= '0;
    end else begin
      if (packet_inc) packet_count <= packet_count + count_width_p'(1);
      if (word_inc)   word_count   <= word_count + count_width_p'(1);
    end
  end

endmodule

// File: rtl/bsg_link_upstream_packer.sv
// Packs {last, data} producer beats into link words for the DDR sender.
// Optional statistics counters are enabled with `define BSG_LINK_PACKER_STATS_EN.
module bsg_link_upstream_packer
  import bsg_link_packer_pkg::*;
#(
  parameter int width_p       = 36,
  parameter int in_width_p    = 8,
  parameter int count_width_p = 16
) (
  input  logic                  core_clk_i,
  input  logic                  core_reset_n_i,
  input  logic [in_width_p-1:0] in_data_i,
  input  logic                  in_last_i,
  input  logic                  in_v_i,
  output logic                  in_ready_o,
  output logic [width_p-1:0]    out_data_o,
  output logic                  out_v_o,
  input  logic                  out_ready_i
`ifdef BSG_LINK_PACKER_STATS_EN
  , output logic [count_width_p-1:0] packet_count_o
  , output logic [count_width_p-1:0] word_count_o
`endif
);

  localparam int slot_lp   = slot_width(in_width_p);
  localparam int els_lp    = els_count(width_p, in_width_p);
  localparam int pack_w_lp = (els_lp > 0) ? els_lp * slot_lp : slot_lp;
  localparam int cnt_w_lp  = (els_lp > 1) ? $clog2(els_lp) : 1;
  localparam logic [cnt_w_lp-1:0] last_slot_lp = cnt_w_lp'((els_lp > 0) ? els_lp - 1 : 0);

  if (els_lp < 1 || width_p < slot_lp || in_width_p < 1 || count_width_p < 1) begin : g_bad_cfg
    $error("bsg_link_upstream_packer: width_p must hold at least one (in_width_p+1)-bit slot");
  end

  out_state_e             state_r, state_n;
  logic [cnt_w_lp-1:0]    cnt_r;
  logic [pack_w_lp-1:0]   fill_r;
  logic [pack_w_lp-1:0]   fill_ins;
  logic [width_p-1:0]     data_r;
  logic [slot_lp-1:0]     slot;
  logic                   accept;
  logic                   complete;
  logic                   xfer;

  assign out_v_o    = (state_r == out_full);
  assign out_data_o = data_r;
  // Ready passes the downstream ready straight through so a full register never costs a bubble.
  assign in_ready_o = core_reset_n_i & (~out_v_o | out_ready_i);

  assign accept   = in_v_i & in_ready_o;
  assign complete = accept & ((cnt_r == last_slot_lp) | in_last_i);
  assign xfer     = out_v_o & out_ready_i;
  assign slot     = {in_last_i, in_data_i};

  always_comb begin
    fill_ins = fill_r;
    for (int k = 0; k < els_lp; k++) begin
      if (cnt_r == cnt_w_lp'(k)) fill_ins[k*slot_lp +: slot_lp] = slot;
    end
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      out_empty: if (complete) state_n = out_full;
      out_full:  if (xfer && !complete) state_n = out_empty;
      default:   state_n = out_empty;
    endcase
  end

  always_ff @(posedge core_clk_i) begin
    if (!core_reset_n_i) begin
      state_r <= out_empty;
      cnt_r   <= '0;
      fill_r  <= '0;
      data_r  <= '0;
    end else begin
      state_r <= state_n;
      if (complete) begin
        cnt_r  <= '0;
        fill_r <= '0;
        data_r <= width_p'(fill_ins);
      end else if (accept) begin
        cnt_r  <= cnt_r + cnt_w_lp'(1);
        fill_r <= fill_ins;
      end
    end
  end

`ifdef BSG_LINK_PACKER_STATS_EN
  bsg_link_packer_stats #(
    .count_width_p(count_width_p)
  ) stats (
    .clk          (core_clk_i),
    .reset_n      (core_reset_n_i),
    .packet_inc   (accept & in_last_i),
    .word_inc     (xfer),
    .packet_count (packet_count_o),
    .word_count   (word_count_o)
  );
`endif

endmodule

// File: tb/tb_bsg_link_upstream_packer.sv
// Directed bench for bsg_link_upstream_packer (36-bit words, 8-bit beats, 4 slots).
// Stats checks run when BSG_LINK_PACKER_STATS_EN is defined.
module tb_bsg_link_upstream_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_v;
  logic        in_ready;
  logic [35:0] out_data;
  logic        out_v;
  logic        out_ready;
`ifdef BSG_LINK_PACKER_STATS_EN
  logic [3:0]  packet_count;
  logic [3:0]  word_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bsg_link_upstream_packer #(
    .width_p      (36),
    .in_width_p   (8),
    .count_width_p(4)
  ) dut (
    .core_clk_i    (clk),
    .core_reset_n_i(rst_n),
    .in_data_i     (in_data),
    .in_last_i     (in_last),
    .in_v_i        (in_v),
    .in_ready_o    (in_ready),
    .out_data_o    (out_data),
    .out_v_o       (out_v),
    .out_ready_i   (out_ready)
`ifdef BSG_LINK_PACKER_STATS_EN
    , .packet_count_o(packet_count)
    , .word_count_o  (word_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    int waited;
    waited  = 0;
    in_v    = 1'b1;
    in_data = d;
    in_last = l;
    #1;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) check_eq("beat_timeout", 64'(in_ready), 64'd1);
    tick();
    in_v = 1'b0;
  endtask

  function automatic logic [35:0] word4(input logic [8:0] s0, s1, s2, s3);
    return {s3, s2, s1, s0};
  endfunction

  logic [7:0] dbeats [4] = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
  logic [7:0] ebeats [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
  logic [7:0] fbeats [3] = '{8'hF0, 8'hF1, 8'hF2};

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_v      = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check_eq("rst_out_v", 64'(out_v), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Full four-beat word
    out_ready = 1'b1;
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    check_eq("full_not_early", 64'(out_v), 64'd0);
    send_beat(8'h44, 1'b0);
    check_eq("full_out_v", 64'(out_v), 64'd1);
    check_eq("full_word", 64'(out_data), 64'h2_20CC_4411);
    tick();
    check_eq("full_drained", 64'(out_v), 64'd0);

    // Short packet: slots 2 and 3 stay zero
    send_beat(8'hAA, 1'b0);
    send_beat(8'hBB, 1'b1);
    check_eq("short_out_v", 64'(out_v), 64'd1);
    check_eq("short_word", 64'(out_data), 64'h0_0003_76AA);
    tick();

    // Backpressure: word held while next beats are offered
    out_ready = 1'b0;
    send_beat(8'hC1, 1'b0);
    send_beat(8'hC2, 1'b0);
    send_beat(8'hC3, 1'b0);
    send_beat(8'hC4, 1'b0);
    check_eq("bp_word", 64'(out_data), 64'(word4(9'h0C1, 9'h0C2, 9'h0C3, 9'h0C4)));
    in_v    = 1'b1;
    in_data = dbeats[0];
    in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
      tick();
      check_eq("bp_hold_v", 64'(out_v), 64'd1);
      check_eq("bp_hold_data", 64'(out_data), 64'(word4(9'h0C1, 9'h0C2, 9'h0C3, 9'h0C4)));
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = dbeats[i];
      tick();
    end
    in_v = 1'b0;
    check_eq("bp_next_v", 64'(out_v), 64'd1);
    check_eq("bp_next_word", 64'(out_data), 64'(word4(9'h0D1, 9'h0D2, 9'h0D3, 9'h0D4)));
    tick();
    check_eq("bp_drained", 64'(out_v), 64'd0);

    // Streaming: eight beats, last on every fourth
    in_v = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = ebeats[i];
      in_last = (i % 4 == 3);
      #1;
      check_eq("stream_in_ready", 64'(in_ready), 64'd1);
      tick();
      if (i == 3) begin
        check_eq("stream_w0_v", 64'(out_v), 64'd1);
        check_eq("stream_w0", 64'(out_data), 64'(word4(9'h001, 9'h002, 9'h003, 9'h104)));
      end
      if (i == 4) check_eq("stream_gap_v", 64'(out_v), 64'd0);
      if (i == 7) begin
        check_eq("stream_w1_v", 64'(out_v), 64'd1);
        check_eq("stream_w1", 64'(out_data), 64'(word4(9'h005, 9'h006, 9'h007, 9'h108)));
      end
    end

    // Back-to-back single-beat packets: transfer and load in the same cycle
    for (int i = 0; i < 3; i++) begin
      in_data = fbeats[i];
      in_last = 1'b1;
      tick();
      check_eq("b2b_v", 64'(out_v), 64'd1);
      check_eq("b2b_word", 64'(out_data), 64'(word4({1'b1, fbeats[i]}, 9'h0, 9'h0, 9'h0)));
    end
    in_v    = 1'b0;
    in_last = 1'b0;
    tick();
    check_eq("b2b_drained", 64'(out_v), 64'd0);

    // Reset mid-packet discards the partial word
    send_beat(8'h55, 1'b0);
    send_beat(8'h66, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_in_ready", 64'(in_ready), 64'd0);
    tick();
    check_eq("midrst_out_v", 64'(out_v), 64'd0);
    check_eq("midrst_out_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;
    send_beat(8'h77, 1'b0);
    send_beat(8'h88, 1'b0);
    send_beat(8'h99, 1'b0);
    check_eq("midrst_no_early", 64'(out_v), 64'd0);
    send_beat(8'hAB, 1'b0);
    check_eq("midrst_clean_v", 64'(out_v), 64'd1);
    check_eq("midrst_clean_word", 64'(out_data), 64'(word4(9'h077, 9'h088, 9'h099, 9'h0AB)));
    tick();

`ifdef BSG_LINK_PACKER_STATS_EN
    rst_n = 1'b0;
    tick();
    check_eq("stats_rst_pkt", 64'(packet_count), 64'd0);
    check_eq("stats_rst_word", 64'(word_count), 64'd0);
    rst_n   = 1'b1;
    in_v    = 1'b1;
    in_last = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = 8'(i);
      tick();
    end
    in_v    = 1'b0;
    in_last = 1'b0;
    tick();
    check_eq("stats_pkt_wrap", 64'(packet_count), 64'd1);
    check_eq("stats_word_wrap", 64'(word_count), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
